// File: rtl/exposure_sequencer_pkg.sv
// Shared types and constants for the exposure sequencer.
package exposure_sequencer_pkg;

  // Clock cycles per countdown-timer tick (the sequencer itself counts in ticks).
  localparam int TICK_DIV   = 1876;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_FWIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_WAIT   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PH_LEAD   = 2'd0,
    PH_EXPOSE = 2'd1,
    PH_TRAIL  = 2'd2
  } phase_e;

endpackage

// File: rtl/exposure_sequencer.sv
// Exposure sequencer: runs lead / expose / trail phases of each frame in a
// burst on the shared countdown timer, drives shutter and sensor gate.
// Zero-length phases are skipped when a phase is entered, so the registered
// outputs (timer load, gates) already reflect the phase actually being run.
module exposure_sequencer
  import exposure_sequencer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int FWIDTH = DEF_FWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  cfg_lead,
  input  logic [WIDTH-1:0]  cfg_exp,
  input  logic [WIDTH-1:0]  cfg_trail,
  input  logic [FWIDTH-1:0] cfg_frames,
  output logic              tmr_load,
  output logic [WIDTH-1:0]  tmr_preset,
  input  logic              tmr_done,
  output logic              busy,
  output logic              shutter_open,
  output logic              sensor_gate,
  output logic              frame_done,
  output logic              aborted
);

  state_e            state_r, state_s;
  phase_e            phase_r, phase_s, enter_ph_s;
  logic [WIDTH-1:0]  lead_r, exp_r, trail_r, lead_s, exp_s, trail_s;
  logic [FWIDTH-1:0] frames_r, frames_s, count_r, count_s;
  logic [WIDTH-1:0]  tmr_preset_s;
  logic              tmr_load_s, busy_s, shutter_s, sensor_s, frame_done_s, aborted_s;
  logic              enter_s, end_frame_s, last_frame_s;

  // Next-state, shadow-config and next-output computation.
  always_comb begin
    state_s      = state_r;
    phase_s      = phase_r;
    lead_s       = lead_r;
    exp_s        = exp_r;
    trail_s      = trail_r;
    frames_s     = frames_r;
    count_s      = count_r;
    tmr_load_s   = 1'b0;
    tmr_preset_s = '0;
    busy_s       = busy;
    shutter_s    = shutter_open;
    sensor_s     = sensor_gate;
    frame_done_s = 1'b0;
    aborted_s    = aborted;
    enter_s      = 1'b0;
    enter_ph_s   = PH_LEAD;
    end_frame_s  = 1'b0;
    last_frame_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          lead_s    = cfg_lead;
          exp_s     = cfg_exp;
          trail_s   = cfg_trail;
          frames_s  = (cfg_frames == '0) ? FWIDTH'(1'b1) : cfg_frames;
          count_s   = '0;
          aborted_s = 1'b0;
          busy_s    = 1'b1;
          enter_s   = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_LOAD, ST_SETTLE, ST_WAIT: begin
        if (abort) begin
          aborted_s = 1'b1;
        end else begin
          aborted_s = aborted;
        end
        // Abort in LEAD/EXPOSE closes the shutter via a freshly loaded TRAIL.
        if (abort && (phase_r != PH_TRAIL)) begin
          enter_s    = 1'b1;
          enter_ph_s = PH_TRAIL;
        end else if (state_r == ST_LOAD) begin
          // A LOAD without a timer load means every remaining phase was empty.
          if (tmr_load) begin
            state_s = ST_SETTLE;
          end else begin
            end_frame_s = 1'b1;
          end
        end else if (state_r == ST_SETTLE) begin
          state_s = ST_WAIT;
        end else if (tmr_done) begin
          if (phase_r == PH_TRAIL) begin
            end_frame_s = 1'b1;
          end else begin
            enter_s    = 1'b1;
            enter_ph_s = (phase_r == PH_LEAD) ? PH_EXPOSE : PH_TRAIL;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        busy_s    = 1'b0;
        shutter_s = 1'b0;
        sensor_s  = 1'b0;
      end
    endcase

    if (end_frame_s) begin
      frame_done_s = 1'b1;
      count_s      = count_r + FWIDTH'(1'b1);
      last_frame_s = (count_s == frames_r) || aborted_s;
      if (last_frame_s) begin
        state_s   = ST_IDLE;
        phase_s   = PH_LEAD;
        busy_s    = 1'b0;
        shutter_s = 1'b0;
        sensor_s  = 1'b0;
      end else begin
        enter_s    = 1'b1;
        enter_ph_s = PH_LEAD;
      end
    end else begin
      last_frame_s = 1'b0;
    end

    // Enter the first non-empty phase at or after the requested one.
    if (enter_s) begin
      state_s = ST_LOAD;
      if ((enter_ph_s == PH_LEAD) && (lead_s != '0)) begin
        phase_s      = PH_LEAD;
        tmr_load_s   = 1'b1;
        tmr_preset_s = lead_s;
        shutter_s    = 1'b1;
        sensor_s     = 1'b0;
      end else if ((enter_ph_s != PH_TRAIL) && (exp_s != '0)) begin
        phase_s      = PH_EXPOSE;
        tmr_load_s   = 1'b1;
        tmr_preset_s = exp_s;
        shutter_s    = 1'b1;
        sensor_s     = 1'b1;
      end else if (trail_s != '0) begin
        phase_s      = PH_TRAIL;
        tmr_load_s   = 1'b1;
        tmr_preset_s = trail_s;
        shutter_s    = 1'b0;
        sensor_s     = 1'b0;
      end else begin
        phase_s      = PH_TRAIL;
        tmr_load_s   = 1'b0;
        shutter_s    = 1'b0;
        sensor_s     = 1'b0;
      end
    end else begin
      tmr_load_s = 1'b0;
    end
  end

  // State, shadow configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      phase_r      <= PH_LEAD;
      lead_r       <= '0;
      exp_r        <= '0;
      trail_r      <= '0;
      frames_r     <= '0;
      count_r      <= '0;
      tmr_load     <= 1'b0;
      tmr_preset   <= '0;
      busy         <= 1'b0;
      shutter_open <= 1'b0;
      sensor_gate  <= 1'b0;
      frame_done   <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state_r      <= state_s;
      phase_r      <= phase_s;
      lead_r       <= lead_s;
      exp_r        <= exp_s;
      trail_r      <= trail_s;
      frames_r     <= frames_s;
      count_r      <= count_s;
      tmr_load     <= tmr_load_s;
      tmr_preset   <= tmr_preset_s;
      busy         <= busy_s;
      shutter_open <= shutter_s;
      sensor_gate  <= sensor_s;
      frame_done   <= frame_done_s;
      aborted      <= aborted_s;
    end
  end

endmodule

// File: tb/tb_exposure_sequencer.sv
// Self-checking bench for exposure_sequencer with a 1-clk-per-tick timer model.
module tb_exposure_sequencer;
  localparam int W  = 16;
  localparam int FW = 8;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [W-1:0]  cfg_lead = '0, cfg_exp = '0, cfg_trail = '0;
  logic [FW-1:0] cfg_frames = '0;
  logic          tmr_load, busy, shutter_open, sensor_gate, frame_done, aborted;
  logic [W-1:0]  tmr_preset;
  logic          tmr_done = 1'b1;
  logic [W-1:0]  tm_cnt = '0;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  exposure_sequencer #(.WIDTH(W), .FWIDTH(FW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_lead(cfg_lead), .cfg_exp(cfg_exp), .cfg_trail(cfg_trail), .cfg_frames(cfg_frames),
    .tmr_load(tmr_load), .tmr_preset(tmr_preset), .tmr_done(tmr_done),
    .busy(busy), .shutter_open(shutter_open), .sensor_gate(sensor_gate),
    .frame_done(frame_done), .aborted(aborted)
  );

  // Fast timer: one tick per clk, done registered from the previous count.
  always @(posedge clk) begin
    tmr_done <= (tm_cnt == '0);
    if (tmr_load) tm_cnt <= tmr_preset;
    else if (tm_cnt != '0) tm_cnt <= tm_cnt - 1'b1;
  end

  // Output monitor: logs timer loads, frame_done cycles and invariant breaks.
  int   cyc = 0, fd_cnt = 0, fd_last_cyc = 0, viol_cnt = 0, bfall_cnt = 0, bfall_bad = 0;
  int   got_pre[$], got_cyc[$];
  bit   got_sh[$], got_se[$];
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    busy_prev <= busy;
    if (tmr_load) begin
      got_pre.push_back(int'(tmr_preset));
      got_sh.push_back(shutter_open);
      got_se.push_back(sensor_gate);
      got_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_last_cyc <= cyc;
    end
    if ((sensor_gate && !shutter_open) || (!tmr_load && tmr_preset != '0)) viol_cnt <= viol_cnt + 1;
    if (rst_n && busy_prev && !busy) begin
      bfall_cnt <= bfall_cnt + 1;
      if (!frame_done) bfall_bad <= bfall_bad + 1;
    end
  end

  // Reference: ordered list of timer loads with the gate levels seen at each.
  int exp_pre[$];
  bit exp_sh[$], exp_se[$];
  int ld_base, fd_base, viol_base, bf_base, bb_base;

  task automatic push_exp(input int p, input bit sh, input bit se);
    exp_pre.push_back(p); exp_sh.push_back(sh); exp_se.push_back(se);
  endtask

  task automatic clear_exp();
    exp_pre.delete(); exp_sh.delete(); exp_se.delete();
  endtask

  // Each frame runs its non-empty phases in order; frames=0 means one frame.
  task automatic model_burst(input int l, input int e, input int t, input int f);
    clear_exp();
    for (int i = 0; i < ((f == 0) ? 1 : f); i++) begin
      if (l != 0) push_exp(l, 1'b1, 1'b0);
      if (e != 0) push_exp(e, 1'b1, 1'b1);
      if (t != 0) push_exp(t, 1'b0, 1'b0);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    ld_base = got_pre.size(); fd_base = fd_cnt; viol_base = viol_cnt;
    bf_base = bfall_cnt; bb_base = bfall_bad;
  endtask

  task automatic wait_idle(input string nm);
    int i = 0;
    while (busy && i < 4000) begin
      tick();
      i++;
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: busy=1 after %0d cycles, expected 0", nm, i);
    end
    tick();
  endtask

  task automatic run_burst(input string nm, input int l, input int e, input int t, input int f);
    snap();
    cfg_lead = W'(l); cfg_exp = W'(e); cfg_trail = W'(t); cfg_frames = FW'(f);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Config changes after acceptance must not affect the running burst.
    cfg_lead = W'($urandom_range(1, 9)); cfg_exp = W'($urandom_range(1, 9));
    cfg_trail = W'($urandom_range(1, 9)); cfg_frames = FW'($urandom_range(1, 5));
    wait_idle(nm);
  endtask

  task automatic check_run(input string nm, input int exp_fd, input logic exp_ab);
    int n_got;
    n_got = got_pre.size() - ld_base;
    chk({nm, "_loads"}, n_got, exp_pre.size());
    for (int i = 0; i < exp_pre.size() && i < n_got; i++)
      chk($sformatf("%s_load%0d", nm, i),
          {got_pre[ld_base+i], got_sh[ld_base+i], got_se[ld_base+i]},
          {exp_pre[i], exp_sh[i], exp_se[i]});
    chk({nm, "_frame_done"}, fd_cnt - fd_base, exp_fd);
    chk({nm, "_aborted"}, aborted, exp_ab);
    chk({nm, "_invariants"}, viol_cnt - viol_base, 0);
    chk({nm, "_busy_fall"}, {bfall_cnt - bf_base, bfall_bad - bb_base}, {32'd1, 32'd0});
  endtask

  typedef struct {
    int lead; int expo; int trail; int frames; int n_loads; int n_fd;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, i, b, r_l, r_e, r_t, r_f;
    vecs[0] = '{3, 5, 2, 1, 3, 1};   // single frame
    vecs[1] = '{1, 2, 1, 3, 9, 3};   // burst of three
    vecs[2] = '{0, 4, 0, 1, 1, 1};   // only exposure
    vecs[3] = '{0, 0, 0, 2, 0, 2};   // all phases empty
    vecs[4] = '{2, 0, 3, 0, 2, 1};   // frames=0 acts as one
    vecs[5] = '{0, 0, 5, 2, 2, 2};   // only trail

    repeat (3) tick();
    chk("reset_outputs", {tmr_load, tmr_preset, busy, shutter_open, sensor_gate, frame_done, aborted}, 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int k = 0; k < 6; k++) begin
      model_burst(vecs[k].lead, vecs[k].expo, vecs[k].trail, vecs[k].frames);
      run_burst($sformatf("vec%0d", k), vecs[k].lead, vecs[k].expo, vecs[k].trail, vecs[k].frames);
      chk($sformatf("vec%0d_tbl_loads", k), got_pre.size() - ld_base, vecs[k].n_loads);
      chk($sformatf("vec%0d_tbl_fd", k), fd_cnt - fd_base, vecs[k].n_fd);
      check_run($sformatf("vec%0d", k), vecs[k].n_fd, 1'b0);
    end

    // Timer is idle with done held high; SETTLE must hide it. Each phase of P
    // ticks spans load cycle + settle + P ticks + one registered-done cycle,
    // so the next load (or frame_done) appears P+3 cycles after the load.
    chk("stale_done_held", tmr_done, 1'b1);
    model_burst(3, 5, 2, 1);
    run_burst("stale", 3, 5, 2, 1);
    check_run("stale", 1, 1'b0);
    b = ld_base;
    if (got_pre.size() >= b + 3) begin
      chk("stale_gap_lead", got_cyc[b+1] - got_cyc[b], 3 + 3);
      chk("stale_gap_exp", got_cyc[b+2] - got_cyc[b+1], 5 + 3);
      chk("stale_gap_trail", fd_last_cyc - got_cyc[b+2], 2 + 3);
    end else begin
      chk("stale_gap_loads", got_pre.size() - b, 3);
    end

    // Abort while idle does nothing.
    abort = 1'b1; tick(); abort = 1'b0; tick();
    chk("abort_idle", {busy, aborted, tmr_load}, 64'd0);

    // Abort two cycles into EXPOSE WAIT of frame 2 of 4.
    clear_exp();
    repeat (2) begin push_exp(2, 1'b1, 1'b0); push_exp(6, 1'b1, 1'b1); push_exp(3, 1'b0, 1'b0); end
    snap();
    cfg_lead = 16'd2; cfg_exp = 16'd6; cfg_trail = 16'd3; cfg_frames = 8'd4;
    start = 1'b1; tick(); start = 1'b0;
    n = 0; i = 0;
    while (n < 2 && i < 500) begin
      if (tmr_load && sensor_gate) n++;
      if (n < 2) tick();
      i++;
    end
    chk("abort_reach_expose2", n, 2);
    repeat (3) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_gates_trail_load", {shutter_open, sensor_gate, tmr_load, tmr_preset}, {1'b0, 1'b0, 1'b1, 16'd3});
    wait_idle("abort_exp");
    check_run("abort_exp", 2, 1'b1);

    // Abort during TRAIL: flag only, trail completes, burst ends.
    clear_exp();
    push_exp(1, 1'b1, 1'b0); push_exp(1, 1'b1, 1'b1); push_exp(4, 1'b0, 1'b0);
    snap();
    cfg_lead = 16'd1; cfg_exp = 16'd1; cfg_trail = 16'd4; cfg_frames = 8'd3;
    start = 1'b1; tick(); start = 1'b0;
    i = 0;
    while (!(tmr_load && !shutter_open) && i < 500) begin tick(); i++; end
    chk("abort_trail_reach", {tmr_load, shutter_open}, 2'b10);
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_trail_flag", {aborted, busy}, 2'b11);
    wait_idle("abort_trail");
    check_run("abort_trail", 1, 1'b1);

    // Start and abort together in IDLE: start wins and clears the sticky flag.
    model_burst(1, 2, 1, 2);
    snap();
    cfg_lead = 16'd1; cfg_exp = 16'd2; cfg_trail = 16'd1; cfg_frames = 8'd2;
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("start_abort_same", {busy, aborted}, 2'b10);
    wait_idle("start_abort");
    check_run("start_abort", 2, 1'b0);

    // Asynchronous reset during LEAD, then a clean frame.
    cfg_lead = 16'd20; cfg_exp = 16'd3; cfg_trail = 16'd3; cfg_frames = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1 chk("reset_async", {tmr_load, tmr_preset, busy, shutter_open, sensor_gate, frame_done, aborted}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    model_burst(3, 5, 2, 1);
    run_burst("after_reset", 3, 5, 2, 1);
    check_run("after_reset", 1, 1'b0);

    // Randomized bursts against the reference.
    for (int k = 0; k < 20; k++) begin
      r_l = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4));
      r_e = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4));
      r_t = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4));
      r_f = int'($urandom_range(0, 3));
      model_burst(r_l, r_e, r_t, r_f);
      run_burst($sformatf("rnd%0d", k), r_l, r_e, r_t, r_f);
      check_run($sformatf("rnd%0d", k), (r_f == 0) ? 1 : r_f, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exposure_sequencer.md
Name: exposure_sequencer

Overview:
- Sequences one exposure frame: shutter lead delay, sensor integration window, then shutter trail/settle delay.
- Drives the shared 16-bit countdown timer (load/preset/done interface, one tick = 1876 clk) in three back-to-back phases.
- Supports bursts of N frames and a mid-frame abort.
- Sits between the control register block (config, start/abort) and the shutter driver / sensor timing gen.

Parameters:
- WIDTH, 16, width of timer preset and phase-length config fields (units: timer ticks).
- FWIDTH, 8, width of burst frame count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse; begins a burst when idle
- abort  in  1  1-cycle pulse; terminates current frame and burst
- cfg_lead  in  WIDTH  lead phase length, ticks
- cfg_exp  in  WIDTH  exposure phase length, ticks
- cfg_trail  in  WIDTH  trail phase length, ticks
- cfg_frames  in  FWIDTH  frames per burst; 0 treated as 1
- tmr_load  out  1  timer load strobe
- tmr_preset  out  WIDTH  timer preset value
- tmr_done  in  1  timer done (registered, level)
- busy  out  1  high from start accept until burst end
- shutter_open  out  1  shutter drive, high during LEAD and EXPOSE
- sensor_gate  out  1  integration enable, high during EXPOSE only
- frame_done  out  1  1-cycle pulse at end of each frame's TRAIL
- aborted  out  1  sticky; set on abort, cleared on next accepted start

Behaviour:
- Clock/reset: single clock clk; reset rst_n asynchronous, active-low. All outputs 0 during and after reset; FSM in IDLE; internal frame counter 0.
- Config latch: cfg_* sampled into shadow regs on the cycle start is accepted. Later changes have no effect until the next start.
- FSM states: IDLE, LOAD, SETTLE, WAIT. A phase register selects LEAD, EXPOSE or TRAIL.
- IDLE:
  - start=1 -> latch config, clear aborted, busy=1, phase=LEAD, go LOAD.
  - start=1 while busy is ignored.
- LOAD:
  - If the current phase length is 0, skip the phase: advance phase (or end frame) in this same state, with no tmr_load.
  - Otherwise assert tmr_load=1 for exactly 1 cycle with tmr_preset = phase length, then go SETTLE.
- SETTLE: one cycle, tmr_done ignored (the timer's done is stale the cycle after load). Go WAIT.
- WAIT: on tmr_done=1 advance LEAD->EXPOSE->TRAIL via LOAD. TRAIL done = end of frame.
- tmr_preset: 0 whenever tmr_load=0.
- Output timing (all outputs registered, change on the cycle the FSM enters the new phase's LOAD):
  - shutter_open: 1 from LEAD LOAD through EXPOSE WAIT.
  - sensor_gate: 1 for EXPOSE LOAD..WAIT.
- End of frame:
  - frame_done pulses 1 cycle; frame counter increments.
  - If count == max(cfg_frames,1): go IDLE, busy=0 in the same cycle as the frame_done pulse.
  - Otherwise phase=LEAD, go LOAD (next frame starts with no idle gap).
- Abort:
  - During LEAD or EXPOSE: shutter_open and sensor_gate drop next cycle; set aborted; jump to TRAIL LOAD (timer reloaded with cfg_trail so blades settle).
  - After that TRAIL: frame_done pulses, then IDLE regardless of remaining frames.
  - Abort during TRAIL: sets aborted only; TRAIL completes normally, then IDLE.
  - Abort in IDLE: ignored.
- Simultaneous events:
  - start and abort in the same cycle in IDLE: start wins, abort ignored.
  - tmr_done and abort in the same WAIT cycle: abort wins.
- All-zero config: each frame takes 2 cycles (LOAD with skips, then frame_done). No tmr_load issued.
- Reset mid-operation: immediate return to IDLE with all outputs low. The timer is not reloaded; its stale done is harmless because the next phase always passes through SETTLE.

Decomposition:
- Shared package:
  - State and phase enum typedefs.
  - TICK_DIV = 1876 (informative, clk per tick).
  - Default WIDTH/FWIDTH.
- No sub-module inside the block. The top level instantiates the countdown timer alongside and connects the tmr_* ports.
- Bench uses a fast timer model (1 clk per tick, same registered-done timing).

Test Plan:
- Single frame: lead=3, exp=5, trail=2, frames=1, start -> exactly 3 tmr_load pulses with presets 3, 5, 2; sensor_gate high only during EXPOSE; 1 frame_done; busy falls with it; aborted=0.
- Burst: frames=3, lead=1, exp=2, trail=1 -> 3 frame_done pulses; 9 tmr_load pulses; shutter_open drops between frames only during TRAIL.
- Zero phase: lead=0, exp=4, trail=0 -> single tmr_load with preset 4; shutter_open and sensor_gate rise together; frame_done follows EXPOSE done.
- Abort in EXPOSE: frames=4, abort 2 cycles into EXPOSE WAIT of frame 2 -> gates low next cycle; tmr_load with preset=trail; 2 frame_done total; aborted=1; IDLE.
- Stale done: timer model holds done=1 before start -> FSM does not advance during SETTLE; phase lengths match presets exactly.
- Reset mid-LEAD: rst_n low asynchronously -> all outputs 0 immediately; a new start after release runs a full frame correctly.
